// File: rtl/mem_stage.sv
// MIPS MEM stage with MEM/WB register: word load/store on a private data memory,
// holding the pipeline through WAIT_STATES extra cycles per aligned access.
module mem_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        In_Valid,
  input  logic [31:0] In_Address,
  input  logic [31:0] In_WriteData,
  input  logic [4:0]  In_WriteReg,
  input  logic [1:0]  In_MEMControl,
  input  logic [1:0]  In_WBControl,
  output logic [31:0] Out_Address,
  output logic [31:0] Out_Data,
  output logic [4:0]  Out_WriteReg,
  output logic [1:0]  Out_WBControl,
  output logic        Out_Misaligned,
  output logic        Out_Stall
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;

  logic        mem_op, misaligned, do_load, do_store;
  logic        stall, complete;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [1:0]  wb_q, wb_d;
  logic        mis_q, mis_d;

  // Upper address bits are deliberately dropped, so addresses alias modulo the depth.
  assign idx = In_Address[ADDR_BITS+1:2];

  always_comb begin
    mem_op     = In_Valid & (In_MEMControl[1] | In_MEMControl[0]);
    misaligned = mem_op & (In_Address[1:0] != 2'b00);
    // MemRead together with MemWrite is a store only.
    do_store   = mem_op & In_MEMControl[0] & ~misaligned;
    do_load    = mem_op & In_MEMControl[1] & ~In_MEMControl[0] & ~misaligned;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned && (WAIT_STATES > 0)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
          stall   = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A stalled edge retires nothing: control bits clear, payload registers hold.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wreg_d = wreg_q;
    wb_d   = 2'b00;
    mis_d  = 1'b0;
    if (complete) begin
      addr_d = In_Address;
      wreg_d = In_WriteReg;
      data_d = do_load ? mem[idx] : 32'd0;
      wb_d   = (In_Valid && !misaligned) ? In_WBControl : 2'b00;
      mis_d  = misaligned;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wreg_q  <= 5'd0;
      wb_q    <= 2'b00;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wreg_q  <= wreg_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: the data memory has no reset; contents survive Rst_n and start undefined.
  always_ff @(posedge Clk) begin
    if (Rst_n && complete && do_store) begin
      mem[idx] <= In_WriteData;
    end
  end

  assign Out_Address    = addr_q;
  assign Out_Data       = data_q;
  assign Out_WriteReg   = wreg_q;
  assign Out_WBControl  = wb_q;
  assign Out_Misaligned = mis_q;
  assign Out_Stall      = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: one instance with 2 wait states, one with none,
// checked against a word-addressed memory model and the stage's retirement rules.
module tb_mem_stage;

  localparam int AB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic [4:0]  in_wreg  [2];
  logic [1:0]  in_mc    [2];
  logic [1:0]  in_wb    [2];
  logic [31:0] out_addr [2];
  logic [31:0] out_data [2];
  logic [4:0]  out_wreg [2];
  logic [1:0]  out_wb   [2];
  logic        out_mis  [2];
  logic        out_stall[2];

  mem_stage #(.ADDR_BITS(AB), .WAIT_STATES(2)) u_dut_ws2 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid[0]), .In_Address(in_addr[0]),
    .In_WriteData(in_wdata[0]), .In_WriteReg(in_wreg[0]), .In_MEMControl(in_mc[0]),
    .In_WBControl(in_wb[0]), .Out_Address(out_addr[0]), .Out_Data(out_data[0]),
    .Out_WriteReg(out_wreg[0]), .Out_WBControl(out_wb[0]), .Out_Misaligned(out_mis[0]),
    .Out_Stall(out_stall[0])
  );

  mem_stage #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_dut_ws0 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid[1]), .In_Address(in_addr[1]),
    .In_WriteData(in_wdata[1]), .In_WriteReg(in_wreg[1]), .In_MEMControl(in_mc[1]),
    .In_WBControl(in_wb[1]), .Out_Address(out_addr[1]), .Out_Data(out_data[1]),
    .Out_WriteReg(out_wreg[1]), .Out_WBControl(out_wb[1]), .Out_Misaligned(out_mis[1]),
    .Out_Stall(out_stall[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model memory keyed by dut*depth + word index; absent key = never written.
  logic [31:0] model_mem [int];
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [4:0]  exp_wreg [2];
  bit          exp_data_known [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic drive_idle(input int d);
    in_valid[d] = 1'b0;
    in_addr[d]  = 32'd0;
    in_wdata[d] = 32'd0;
    in_wreg[d]  = 5'd0;
    in_mc[d]    = 2'b00;
    in_wb[d]    = 2'b00;
  endtask

  task automatic clear_expect(input int d);
    exp_addr[d]       = 32'd0;
    exp_data[d]       = 32'd0;
    exp_wreg[d]       = 5'd0;
    exp_data_known[d] = 1'b1;
  endtask

  task automatic check_reset(input int d);
    check("rst_addr", out_addr[d], 32'd0);
    check("rst_data", out_data[d], 32'd0);
    check("rst_wreg", 32'(out_wreg[d]), 32'd0);
    check("rst_wb",   32'(out_wb[d]), 32'd0);
    check("rst_mis",  32'(out_mis[d]), 32'd0);
  endtask

  // Present one instruction to dut d and follow it until it retires.
  task automatic run_op(input int d, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] wr,
                        input logic [1:0] mc, input logic [1:0] wb);
    bit memop, mis, is_load, is_store;
    int stalls, key;
    @(negedge clk);
    drive_idle(1 - d);
    in_valid[d] = v;
    in_addr[d]  = a;
    in_wdata[d] = wd;
    in_wreg[d]  = wr;
    in_mc[d]    = mc;
    in_wb[d]    = wb;
    memop    = v && (mc != 2'b00);
    mis      = memop && (a % 4 != 0);
    is_store = memop && mc[0] && !mis;
    is_load  = memop && (mc == 2'b10) && !mis;
    stalls   = (memop && !mis) ? ws_of(d) : 0;
    key      = d * (1 << AB) + int'((a / 4) % (1 << AB));
    for (int i = 0; i <= stalls; i++) begin
      #1;
      check("stall", 32'(out_stall[d]), 32'(i < stalls));
      @(posedge clk);
      #1;
      if (i < stalls) begin
        check("hold_wb",   32'(out_wb[d]), 32'd0);
        check("hold_mis",  32'(out_mis[d]), 32'd0);
        check("hold_addr", out_addr[d], exp_addr[d]);
        check("hold_wreg", 32'(out_wreg[d]), 32'(exp_wreg[d]));
        if (exp_data_known[d]) check("hold_data", out_data[d], exp_data[d]);
        @(negedge clk);
      end
    end
    exp_addr[d] = a;
    exp_wreg[d] = wr;
    if (is_load) begin
      exp_data_known[d] = model_mem.exists(key);
      exp_data[d] = exp_data_known[d] ? model_mem[key] : 32'd0;
    end else begin
      exp_data_known[d] = 1'b1;
      exp_data[d] = 32'd0;
    end
    check("ret_addr", out_addr[d], exp_addr[d]);
    check("ret_wreg", 32'(out_wreg[d]), 32'(exp_wreg[d]));
    check("ret_wb",   32'(out_wb[d]), (v && !mis) ? 32'(wb) : 32'd0);
    check("ret_mis",  32'(out_mis[d]), 32'(mis));
    if (exp_data_known[d]) check("ret_data", out_data[d], exp_data[d]);
    if (is_store) model_mem[key] = wd;
    clear_expect(1 - d);
  endtask

  initial begin
    logic [31:0] r, a;
    int d, idx, low;

    drive_idle(0);
    drive_idle(1);
    clear_expect(0);
    clear_expect(1);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    check("rst_stall", 32'(out_stall[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a store's wait states must drop the write.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_addr[0]  = 32'h10;
    in_wdata[0] = 32'hDEADBEEF;
    in_wreg[0]  = 5'd0;
    in_mc[0]    = 2'b01;
    in_wb[0]    = 2'b00;
    @(posedge clk);
    #1;
    check("t1_in_wait", 32'(out_stall[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    drive_idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_expect(0);
    clear_expect(1);
    run_op(0, 1'b1, 32'h10, 32'd0, 5'd2, 2'b10, 2'b11);
    check("t1_no_write", 32'(out_data[0] == 32'hDEADBEEF), 32'd0);

    // Give both memories known contents in the word range the random phase uses.
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 16; i++)
        run_op(dd, 1'b1, 32'(i * 4), $urandom, 5'd0, 2'b01, 2'b00);

    run_op(0, 1'b1, 32'h40, 32'h12345678, 5'd3, 2'b01, 2'b00);
    run_op(0, 1'b1, 32'h40, 32'd0, 5'd7, 2'b10, 2'b11);
    check("t2_load", out_data[0], 32'h12345678);
    check("t2_wb", 32'(out_wb[0]), 32'd3);

    run_op(0, 1'b1, 32'h5, 32'd0, 5'd4, 2'b00, 2'b01);
    check("t3_addr", out_addr[0], 32'h5);

    run_op(0, 1'b1, 32'h0000_0402, 32'd0, 5'd1, 2'b10, 2'b11);
    check("t4_mis", 32'(out_mis[0]), 32'd1);

    run_op(0, 1'b1, 32'h0, 32'hAA, 5'd0, 2'b01, 2'b00);
    run_op(0, 1'b1, 32'(4 << AB), 32'd0, 5'd9, 2'b10, 2'b11);
    check("t5_alias", out_data[0], 32'hAA);

    run_op(1, 1'b1, 32'h80, 32'hCAFE_F00D, 5'd0, 2'b01, 2'b00);
    run_op(1, 1'b1, 32'h80, 32'd0, 5'd6, 2'b10, 2'b11);
    check("t6_load", out_data[1], 32'hCAFE_F00D);

    run_op(0, 1'b1, 32'h44, 32'h55, 5'd8, 2'b11, 2'b11);
    check("rw_data0", out_data[0], 32'd0);
    run_op(0, 1'b1, 32'h44, 32'd0, 5'd8, 2'b10, 2'b11);
    check("rw_store", out_data[0], 32'h55);
    run_op(0, 1'b0, 32'h48, 32'd0, 5'd5, 2'b10, 2'b11);
    check("bubble_wb", 32'(out_wb[0]), 32'd0);

    for (int n = 0; n < 400; n++) begin
      d   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      low = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      r   = $urandom;
      a   = (r << (AB + 2)) | (32'(idx) << 2) | 32'(low);
      run_op(d, ($urandom_range(0, 7) != 0), a, $urandom, 5'($urandom),
             2'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
